// File: rtl/vga_fml_arbiter.sv
// Two-master FML burst arbiter: fixed priority to m0 (display refill), with a starvation guard for m1.
// Optional per-master burst counters are built when VGA_FML_ARB_STATS_EN is defined.
module vga_fml_arbiter #(
  parameter int fml_depth    = 20,
  parameter int BURST_LEN    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [fml_depth-1:0] m0_adr_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [1:0]           m0_sel_i,
  input  logic [15:0]          m0_dw_i,
  output logic                 m0_ack_o,
  input  logic [fml_depth-1:0] m1_adr_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [1:0]           m1_sel_i,
  input  logic [15:0]          m1_dw_i,
  output logic                 m1_ack_o,
  output logic [15:0]          m_dr_o,
  output logic [fml_depth-1:0] fml_adr_o,
  output logic                 fml_stb_o,
  output logic                 fml_we_o,
  output logic [1:0]           fml_sel_o,
  output logic [15:0]          fml_do,
  input  logic                 fml_ack_i,
  input  logic [15:0]          fml_di,
  output logic [15:0]          m0_grants_o,
  output logic [15:0]          m1_grants_o,
  output logic                 busy_o
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_TURN} state_t;
  typedef enum logic [1:0] {G_NONE, G_M0, G_M1} grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [3:0]    starve_q, starve_d;

  always_ff @(posedge clk_i) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q  <= S_IDLE;
      grant_q  <= G_NONE;
      beat_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    unique case (state_q)
      S_IDLE: begin
        if (m1_stb_i && (!m0_stb_i || starve_q == STARVE_MAX)) begin
          grant_d  = G_M1;
          starve_d = '0;
          state_d  = S_REQ;
        end else if (m0_stb_i) begin
          grant_d = G_M0;
          state_d = S_REQ;
          // Only a run of m0 grants that actually blocks m1 counts toward starvation.
          if (!m1_stb_i)                  starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
        end
      end
      S_REQ: begin
        if (fml_ack_i) begin
          beat_d  = BW'(1);
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          grant_d = G_NONE;
          state_d = S_TURN;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_TURN: begin
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  logic gnt0, gnt1;
  assign gnt0 = (grant_q == G_M0);
  assign gnt1 = (grant_q == G_M1);

  always_comb begin
    fml_adr_o = '0;
    fml_we_o  = 1'b0;
    fml_sel_o = '0;
    fml_do    = '0;
    if (gnt0) begin
      fml_adr_o = m0_adr_i;
      fml_we_o  = m0_we_i;
      fml_sel_o = m0_sel_i;
      fml_do    = m0_dw_i;
    end else if (gnt1) begin
      fml_adr_o = m1_adr_i;
      fml_we_o  = m1_we_i;
      fml_sel_o = m1_sel_i;
      fml_do    = m1_dw_i;
    end
  end

  assign fml_stb_o = (state_q == S_REQ);
  assign m0_ack_o  = fml_stb_o && gnt0 && fml_ack_i;
  assign m1_ack_o  = fml_stb_o && gnt1 && fml_ack_i;
  assign busy_o    = (state_q != S_IDLE);
  assign m_dr_o    = fml_di;

`ifdef VGA_FML_ARB_STATS_EN
  logic [15:0] m0_cnt_q, m0_cnt_d;
  logic [15:0] m1_cnt_q, m1_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m0_cnt_q <= '0;
      m1_cnt_q <= '0;
    end else begin
      m0_cnt_q <= m0_cnt_d;
      m1_cnt_q <= m1_cnt_d;
    end
  end

  always_comb begin
    m0_cnt_d = m0_cnt_q;
    m1_cnt_d = m1_cnt_q;
    if (m0_ack_o && m0_cnt_q != 16'hFFFF) m0_cnt_d = m0_cnt_q + 16'd1;
    if (m1_ack_o && m1_cnt_q != 16'hFFFF) m1_cnt_d = m1_cnt_q + 16'd1;
  end

  assign m0_grants_o = m0_cnt_q;
  assign m1_grants_o = m1_cnt_q;
`else
  assign m0_grants_o = '0;
  assign m1_grants_o = '0;
`endif

endmodule

// File: tb/tb_vga_fml_arbiter.sv
// Randomised bench for vga_fml_arbiter: reactive masters and slave, a transaction-level
// arbitration model compared every cycle, and directed scenarios with literal expectations.
module tb_vga_fml_arbiter;
  localparam int FD = 20;
  localparam int BL = 8;
  localparam int SL = 4;
`ifdef VGA_FML_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [FD-1:0] adr;
    logic          we;
    logic [1:0]    sel;
    logic [15:0]   salt;
  } req_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [FD-1:0] m_adr [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [1:0]    m_sel [2];
  logic [15:0]   m_dw  [2];
  logic          m0_ack_o, m1_ack_o;
  logic [15:0]   m_dr_o;
  logic [FD-1:0] fml_adr_o;
  logic          fml_stb_o, fml_we_o;
  logic [1:0]    fml_sel_o;
  logic [15:0]   fml_do;
  logic          fml_ack_i;
  logic [15:0]   fml_di;
  logic [15:0]   m0_grants_o, m1_grants_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  vga_fml_arbiter #(.fml_depth(FD), .BURST_LEN(BL), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m_adr[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_dw_i(m_dw[0]), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m_adr[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_dw_i(m_dw[1]), .m1_ack_o(m1_ack_o),
    .m_dr_o(m_dr_o),
    .fml_adr_o(fml_adr_o), .fml_stb_o(fml_stb_o), .fml_we_o(fml_we_o), .fml_sel_o(fml_sel_o),
    .fml_do(fml_do), .fml_ack_i(fml_ack_i), .fml_di(fml_di),
    .m0_grants_o(m0_grants_o), .m1_grants_o(m1_grants_o), .busy_o(busy_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Master / slave stimulus state
  req_t        q0[$], q1[$];
  req_t        drv_r;
  bit          drv_got;
  logic [15:0] salt [2];
  int          beat [2];
  bit          auto_req [2];
  bit          ack_seen [2];
  bit          stb_seen;
  int          slave_fixed, scnt, sdelay;

  // Observation for directed checks
  int            busy_cnt;
  int            ack_cnt [2];
  logic [FD-1:0] cap_adr;
  logic          cap_we;
  logic [1:0]    cap_sel;
  logic [15:0]   cap_do [BL];
  int            cap_idx;
  bit            prev_stb;

  // Reference model: owner -1 = nobody; beat -1 = waiting for slave ack, 1..BL-1 = data beats
  int  mdl_owner = -1;
  int  mdl_beat  = 0;
  bit  mdl_dead  = 1'b0;
  int  mdl_starve = 0;
  int  mdl_cnt [2];
  int  grant_log[$];
  bit  mdl_ok = 1'b0;
  int  cmp_o;
  bit  e_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input int m, input logic [FD-1:0] adr, input logic we,
                          input logic [1:0] sel, input logic [15:0] s);
    req_t r;
    r.adr = adr; r.we = we; r.sel = sel; r.salt = s;
    if (m == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  function automatic logic [15:0] pat(input int i, input int k);
    logic [31:0] p;
    p = 32'h1111 * 32'(k + 1);
    return salt[i] ^ p[15:0];
  endfunction

  // Reactive masters and slave, driven 1 time unit after the active edge
  always @(posedge clk_i) begin
    #1;
    if (fml_ack_i) begin
      fml_ack_i = 1'b0;
      scnt = 0;
    end else if (stb_seen) begin
      if (scnt == 0) sdelay = (slave_fixed > 0) ? slave_fixed : int'($urandom_range(1, 4));
      scnt++;
      if (scnt >= sdelay) fml_ack_i = 1'b1;
    end else begin
      scnt = 0;
    end
    fml_di = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (ack_seen[i]) begin
        m_stb[i] = 1'b0;
        beat[i]  = 1;
      end else if (beat[i] != 0) begin
        beat[i] = (beat[i] == BL - 1) ? 0 : beat[i] + 1;
      end
      if (auto_req[i] && !m_stb[i] && $urandom_range(0, 2) == 0)
        push_req(i, FD'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
      drv_got = 1'b0;
      if (!m_stb[i]) begin
        if (i == 0 && q0.size() > 0) begin drv_r = q0.pop_front(); drv_got = 1'b1; end
        if (i == 1 && q1.size() > 0) begin drv_r = q1.pop_front(); drv_got = 1'b1; end
      end
      if (drv_got) begin
        m_stb[i] = 1'b1;
        m_adr[i] = drv_r.adr;
        m_we[i]  = drv_r.we;
        m_sel[i] = drv_r.sel;
        salt[i]  = drv_r.salt;
      end
      if (beat[i] != 0)  m_dw[i] = pat(i, beat[i]);
      else if (m_stb[i]) m_dw[i] = pat(i, 0);
      else               m_dw[i] = 16'($urandom);
    end
  end

  // Observe, compare against the model, then advance the model on the inputs the DUT will sample
  always @(negedge clk_i) begin
    stb_seen    = fml_stb_o;
    ack_seen[0] = m0_ack_o;
    ack_seen[1] = m1_ack_o;
    if (busy_o)   busy_cnt++;
    if (m0_ack_o) ack_cnt[0]++;
    if (m1_ack_o) ack_cnt[1]++;
    if (fml_stb_o && !prev_stb) begin
      cap_adr = fml_adr_o; cap_we = fml_we_o; cap_sel = fml_sel_o;
    end
    prev_stb = fml_stb_o;
    if (m0_ack_o || m1_ack_o) begin
      cap_do[0] = fml_do;
      cap_idx = 1;
    end else if (cap_idx < BL) begin
      cap_do[cap_idx] = fml_do;
      cap_idx++;
    end

    if (mdl_ok) begin
      e_act = (mdl_owner >= 0);
      cmp_o = (mdl_owner == 1) ? 1 : 0;
      check("busy",    32'(busy_o),    32'(e_act || mdl_dead));
      check("fml_stb", 32'(fml_stb_o), 32'(e_act && mdl_beat < 0));
      check("fml_adr", 32'(fml_adr_o), e_act ? 32'(m_adr[cmp_o]) : 32'd0);
      check("fml_we",  32'(fml_we_o),  e_act ? 32'(m_we[cmp_o])  : 32'd0);
      check("fml_sel", 32'(fml_sel_o), e_act ? 32'(m_sel[cmp_o]) : 32'd0);
      check("fml_do",  32'(fml_do),    e_act ? 32'(m_dw[cmp_o])  : 32'd0);
      check("m0_ack",  32'(m0_ack_o),  32'(mdl_owner == 0 && mdl_beat < 0 && fml_ack_i));
      check("m1_ack",  32'(m1_ack_o),  32'(mdl_owner == 1 && mdl_beat < 0 && fml_ack_i));
      check("m_dr",    32'(m_dr_o),    32'(fml_di));
      check("m0_grants", 32'(m0_grants_o), STATS ? 32'(mdl_cnt[0]) : 32'd0);
      check("m1_grants", 32'(m1_grants_o), STATS ? 32'(mdl_cnt[1]) : 32'd0);
    end

    if (rst_i) begin
      mdl_owner = -1; mdl_beat = 0; mdl_dead = 1'b0; mdl_starve = 0;
      mdl_cnt[0] = 0; mdl_cnt[1] = 0; mdl_ok = 1'b1;
    end else if (mdl_dead) begin
      mdl_dead = 1'b0;
    end else if (mdl_owner < 0) begin
      if (m_stb[1] && (!m_stb[0] || mdl_starve == SL)) begin
        mdl_owner = 1; mdl_starve = 0;
      end else if (m_stb[0]) begin
        mdl_owner = 0;
        mdl_starve = m_stb[1] ? ((mdl_starve < SL) ? mdl_starve + 1 : SL) : 0;
      end
      if (mdl_owner >= 0) begin
        mdl_beat = -1;
        grant_log.push_back(mdl_owner);
      end
    end else if (mdl_beat < 0) begin
      if (fml_ack_i) begin
        mdl_beat = 1;
        if (mdl_cnt[mdl_owner] < 65535) mdl_cnt[mdl_owner]++;
      end
    end else if (mdl_beat == BL - 1) begin
      mdl_owner = -1; mdl_dead = 1'b1;
    end else begin
      mdl_beat++;
    end
  end

  task automatic wait_quiet(input int max_cyc, input string name);
    int  n = 0;
    bit  quiet = 1'b0;
    while (!quiet && n < max_cyc) begin
      @(negedge clk_i);
      n++;
      quiet = !busy_o && !m_stb[0] && !m_stb[1] && q0.size() == 0 && q1.size() == 0;
    end
    check({name, "_settled"}, 32'(quiet), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_log [7];
    rst_i = 1'b1; fml_ack_i = 1'b0; fml_di = '0;
    for (int i = 0; i < 2; i++) begin
      m_stb[i] = 1'b0; m_adr[i] = '0; m_we[i] = 1'b0; m_sel[i] = '0; m_dw[i] = '0;
      beat[i] = 0; auto_req[i] = 1'b0; salt[i] = '0; ack_seen[i] = 1'b0; ack_cnt[i] = 0;
      mdl_cnt[i] = 0;
    end
    stb_seen = 1'b0; slave_fixed = 3; scnt = 0; sdelay = 1;
    busy_cnt = 0; cap_idx = BL; prev_stb = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst_busy",  32'(busy_o),    32'd0);
    check("rst_stb",   32'(fml_stb_o), 32'd0);
    check("rst_adr",   32'(fml_adr_o), 32'd0);
    check("rst_m0grn", 32'(m0_grants_o), 32'd0);

    // Single m0 read, slave acks 3 cycles after strobe
    busy_cnt = 0; ack_cnt[0] = 0; ack_cnt[1] = 0;
    push_req(0, 20'h00120, 1'b0, 2'b11, 16'h0000);
    wait_quiet(100, "m0rd");
    check("m0rd_adr",  32'(cap_adr), 32'h00120);
    check("m0rd_we",   32'(cap_we),  32'd0);
    check("m0rd_ack0", 32'(ack_cnt[0]), 32'd1);
    check("m0rd_ack1", 32'(ack_cnt[1]), 32'd0);
    check("m0rd_busy_cycles", 32'(busy_cnt), 32'd12);

    // Single m1 write with beat pattern 0x1111..0x8888
    push_req(1, 20'h00340, 1'b1, 2'b11, 16'h0000);
    wait_quiet(100, "m1wr");
    check("m1wr_adr", 32'(cap_adr), 32'h00340);
    check("m1wr_we",  32'(cap_we),  32'd1);
    check("m1wr_sel", 32'(cap_sel), 32'd3);
    for (int k = 0; k < BL; k++)
      check($sformatf("m1wr_beat%0d", k), 32'(cap_do[k]), 32'h1111 * 32'(k + 1));

    // Simultaneous requests: m0 then m1
    grant_log.delete();
    push_req(0, 20'h00400, 1'b0, 2'b01, 16'h1234);
    push_req(1, 20'h00500, 1'b1, 2'b10, 16'h4321);
    wait_quiet(100, "simul");
    check("simul_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("simul_first",  32'(grant_log[0]), 32'd0);
      check("simul_second", 32'(grant_log[1]), 32'd1);
    end

    // Starvation: m0 continuous, m1 pending
    grant_log.delete();
    for (int i = 0; i < 6; i++) push_req(0, 20'(32'h01000 + 32'(i) * 32'h10), 1'b0, 2'b11, 16'(i));
    push_req(1, 20'h02000, 1'b0, 2'b11, 16'hBEEF);
    wait_quiet(400, "starve");
    exp_log = '{0, 0, 0, 0, 1, 0, 0};
    check("starve_count", 32'(grant_log.size()), 32'd7);
    if (grant_log.size() == 7)
      for (int i = 0; i < 7; i++)
        check($sformatf("starve_grant%0d", i), 32'(grant_log[i]), 32'(exp_log[i]));

    // Reset at beat 3 of an m1 burst with an m0 request pending
    ack_cnt[1] = 0;
    push_req(1, 20'h00560, 1'b0, 2'b01, 16'h0F0F);
    n = 0;
    while (ack_cnt[1] == 0 && n < 100) begin @(posedge clk_i); n++; end
    check("rstmid_ack_seen", 32'(ack_cnt[1] != 0), 32'd1);
    push_req(0, 20'h0ABC0, 1'b0, 2'b11, 16'h5555);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_busy", 32'(busy_o),    32'd0);
    check("rstmid_stb",  32'(fml_stb_o), 32'd0);
    check("rstmid_adr",  32'(fml_adr_o), 32'd0);
    @(negedge clk_i);
    check("rstmid_regrant_stb", 32'(fml_stb_o), 32'd1);
    check("rstmid_regrant_adr", 32'(fml_adr_o), 32'h0ABC0);
    wait_quiet(100, "rstmid");

    // Burst counters: 5 m0 and 2 m1 bursts after a clean reset
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 5; i++) push_req(0, 20'(32'h03000 + 32'(i)), 1'b0, 2'b11, 16'(32'h100 + i));
    for (int i = 0; i < 2; i++) push_req(1, 20'(32'h04000 + 32'(i)), 1'b1, 2'b11, 16'(32'h200 + i));
    wait_quiet(600, "stats");
    check("stats_model_m0", 32'(mdl_cnt[0]), 32'd5);
    check("stats_model_m1", 32'(mdl_cnt[1]), 32'd2);
    check("stats_m0", 32'(m0_grants_o), STATS ? 32'd5 : 32'd0);
    check("stats_m1", 32'(m1_grants_o), STATS ? 32'd2 : 32'd0);

    // Random traffic with variable slave latency and rare resets
    slave_fixed = 0;
    auto_req[0] = 1'b1;
    auto_req[1] = 1'b1;
    repeat (4000) begin
      @(posedge clk_i);
      #1 rst_i = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    auto_req[0] = 1'b0;
    auto_req[1] = 1'b0;
    wait_quiet(300, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
